// File: rtl/if_fetch_queue_pkg.sv
// Shared constants, queue entry layout and kseg address mapping for the fetch stage.
package if_fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
    localparam logic [7:0]  EXC_ADEL         = 8'h04;
    localparam logic [2:0]  KSEG0_TOP        = 3'b100;
    localparam logic [2:0]  KSEG1_TOP        = 3'b101;

    typedef struct packed {
        logic        exc;
        logic [31:0] pc;
        logic [31:0] inst;
    } q_entry_t;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB; everything else passes through.
    function automatic logic [31:0] map_addr(input logic [31:0] va);
        if (va[31:29] == KSEG0_TOP || va[31:29] == KSEG1_TOP)
            return {3'b000, va[28:0]};
        return va;
    endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; used for the instruction queue and PC tags.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: pipelined bus requests with credit control, in-flight PC tags,
// stale-return discard after redirects, and an AdEL entry for misaligned fetch PCs.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_allowin_in,
    output logic        if_valid_out,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_NNPC_out,
    output logic [31:0] if_Instruct_out,
    output logic        if_exc_out,
    output logic [7:0]  if_ExcCode_out,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam int unsigned CW  = $clog2(MAX_OUT + 1);
    localparam int unsigned QCW = $clog2(DEPTH + 1);

    logic [31:0]    pc;
    logic           halted;
    logic [CW-1:0]  outstanding, discard;
    logic           misaligned, hs, keep_word, exc_push;
    logic [31:0]    out_ext, used_ext;

    logic [QCW-1:0] q_count;
    logic           q_full, q_empty, q_push, q_pop;
    q_entry_t       q_din, q_head;

    logic [31:0]    tag_pc;
    logic [CW-1:0]  tag_count;
    logic           tag_full, tag_empty;

    always_comb begin
        out_ext    = 32'(outstanding);
        used_ext   = 32'(outstanding) + 32'(q_count);
        misaligned = (pc[1:0] != 2'b00);
        inst_req   = rst_n && !redirect_valid && !halted && !misaligned
                     && (out_ext < MAX_OUT) && (used_ext < DEPTH);
        inst_addr  = map_addr(pc);
        hs         = inst_req && inst_addr_ok;
        keep_word  = inst_data_ok && (discard == '0) && !redirect_valid;
        exc_push   = !redirect_valid && !halted && misaligned
                     && (outstanding == '0) && !q_full;
        q_push     = keep_word || exc_push;
        q_pop      = !q_empty && id_allowin_in && !redirect_valid;
        q_din      = '0;
        if (exc_push) begin
            q_din.exc = 1'b1;
            q_din.pc  = pc;
        end else begin
            q_din.pc   = tag_pc;
            q_din.inst = inst_rdata;
        end
    end

    // Every request still in flight at a redirect is stale, so discard covers all of them
    // (including ones already marked stale by an earlier redirect) rather than accumulating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            halted      <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(hs) - CW'(inst_data_ok);
            if (redirect_valid) begin
                pc      <= redirect_pc;
                halted  <= 1'b0;
                discard <= outstanding - CW'(inst_data_ok);
            end else begin
                if (hs)                                pc      <= pc + 32'd4;
                if (exc_push)                          halted  <= 1'b1;
                if (inst_data_ok && discard != '0)     discard <= discard - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(q_entry_t))
    ) u_inst_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redirect_valid),
        .din   (q_din),
        .dout  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Tags are never flushed: each return, kept or dropped, consumes its own tag in order.
    fetch_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (32)
    ) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (hs),
        .pop   (inst_data_ok),
        .flush (1'b0),
        .din   (pc),
        .dout  (tag_pc),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_comb begin
        if_valid_out    = !q_empty;
        if_PC_out       = '0;
        if_NPC_out      = '0;
        if_NNPC_out     = '0;
        if_Instruct_out = '0;
        if_exc_out      = 1'b0;
        if_ExcCode_out  = '0;
        if (!q_empty) begin
            if_PC_out       = q_head.pc;
            if_NPC_out      = q_head.pc + 32'd4;
            if_NNPC_out     = q_head.pc + 32'd8;
            if_Instruct_out = q_head.inst;
            if_exc_out      = q_head.exc;
            if_ExcCode_out  = q_head.exc ? EXC_ADEL : 8'h00;
        end
    end

    a_no_orphan_data: assert property (@(posedge clk) disable iff (!rst_n)
        inst_data_ok |-> (outstanding != '0 && !tag_empty));
    a_tag_tracks: assert property (@(posedge clk) disable iff (!rst_n)
        (tag_count == outstanding) && !(hs && tag_full));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue: bus responder plus a PC-stream reference model.
module tb_if_fetch_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_allowin_in;
    logic        if_valid_out;
    logic [31:0] if_PC_out, if_NPC_out, if_NNPC_out, if_Instruct_out;
    logic        if_exc_out;
    logic [7:0]  if_ExcCode_out;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (32'hbfc0_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_allowin_in   (id_allowin_in),
        .if_valid_out    (if_valid_out),
        .if_PC_out       (if_PC_out),
        .if_NPC_out      (if_NPC_out),
        .if_NNPC_out     (if_NNPC_out),
        .if_Instruct_out (if_Instruct_out),
        .if_exc_out      (if_exc_out),
        .if_ExcCode_out  (if_ExcCode_out),
        .inst_req        (inst_req),
        .inst_addr       (inst_addr),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned ready;
    } req_t;

    req_t        pend[$];
    int unsigned cyc, n_cmp, n_err, n_hs, n_pops;
    logic [31:0] exp_pc, req_pc, first_hs_addr, first_pop_pc;
    bit          exp_done, seen_hs, seen_pop, last_req;

    function automatic logic [31:0] phys(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'ha000_0000) return va - 32'h8000_0000;
        if (va >= 32'ha000_0000 && va < 32'hc000_0000) return va - 32'ha000_0000;
        return va;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pa);
        return (pa * 32'h9e37_79b1) ^ 32'h1357_2468;
    endfunction

    task automatic model_redirect(input logic [31:0] t);
        exp_pc   = t;
        req_pc   = t;
        exp_done = 1'b0;
        seen_hs  = 1'b0;
        seen_pop = 1'b0;
    endtask

    // Head must walk target, target+4, ... from the last redirect; one AdEL entry then nothing.
    task automatic check_head();
        logic [31:0] e_inst;
        logic        e_exc;
        n_cmp++;
        if (exp_done) begin
            n_err++;
            $display("FAIL extra_pop: got PC %h, required no entry after AdEL", if_PC_out);
            return;
        end
        e_exc  = (exp_pc[1:0] != 2'b00);
        e_inst = e_exc ? 32'h0 : word_at(phys(exp_pc));
        if (if_PC_out !== exp_pc || if_NPC_out !== exp_pc + 32'd4 || if_NNPC_out !== exp_pc + 32'd8
            || if_Instruct_out !== e_inst || if_exc_out !== e_exc
            || if_ExcCode_out !== (e_exc ? 8'h04 : 8'h00)) begin
            n_err++;
            $display("FAIL head: got pc=%h npc=%h nnpc=%h inst=%h exc=%b code=%h, required pc=%h inst=%h exc=%b",
                     if_PC_out, if_NPC_out, if_NNPC_out, if_Instruct_out, if_exc_out, if_ExcCode_out,
                     exp_pc, e_inst, e_exc);
        end
        if (!seen_pop) first_pop_pc = if_PC_out;
        seen_pop = 1'b1;
        n_pops++;
        if (e_exc) exp_done = 1'b1;
        else       exp_pc   = exp_pc + 32'd4;
    endtask

    task automatic bus_cycle(input bit redir, input logic [31:0] rpc, input bit allow,
                             input int unsigned aok_pct, input int unsigned lat_lo,
                             input int unsigned lat_hi);
        bit          hs, dok;
        logic [31:0] a;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_allowin_in  = allow;
        inst_addr_ok   = ($urandom_range(99, 0) < aok_pct);
        if (pend.size() > 0 && pend[0].ready <= cyc) begin
            inst_data_ok = 1'b1;
            inst_rdata   = word_at(pend[0].addr);
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = $urandom;
        end
        #1;
        hs       = inst_req && inst_addr_ok;
        dok      = inst_data_ok;
        a        = inst_addr;
        last_req = inst_req;
        if (redir) begin
            n_cmp++;
            if (inst_req !== 1'b0) begin
                n_err++;
                $display("FAIL req_during_redirect: got inst_req=%b, required 0", inst_req);
            end
        end
        if (hs) begin
            n_cmp++;
            if (req_pc[1:0] != 2'b00 || a !== phys(req_pc)) begin
                n_err++;
                $display("FAIL req_addr: got %h, required %h (fetch pc %h)", a, phys(req_pc), req_pc);
            end
            if (!seen_hs) first_hs_addr = a;
            seen_hs = 1'b1;
            n_hs++;
            req_pc = req_pc + 32'd4;
        end
        if (if_valid_out && allow && !redir) check_head();
        @(posedge clk);
        cyc++;
        if (dok) void'(pend.pop_front());
        if (hs) pend.push_back('{addr: a, ready: cyc + $urandom_range(lat_hi, lat_lo) - 1});
        if (redir) model_redirect(rpc);
        n_cmp++;
        if (pend.size() > MAX_OUT) begin
            n_err++;
            $display("FAIL outstanding: got %0d, required <= %0d", pend.size(), MAX_OUT);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_allowin_in = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (if_valid_out !== 1'b0 || inst_req !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid=%b req=%b, required 0 0", if_valid_out, inst_req);
        end
        n_cmp++;
        if (if_PC_out !== '0 || if_NPC_out !== '0 || if_NNPC_out !== '0 || if_Instruct_out !== '0
            || if_exc_out !== 1'b0 || if_ExcCode_out !== '0) begin
            n_err++;
            $display("FAIL reset_head: got pc=%h inst=%h exc=%b code=%h, required all 0",
                     if_PC_out, if_Instruct_out, if_exc_out, if_ExcCode_out);
        end
        rst_n = 1'b1;
        cyc   = 0;
        pend.delete();
        model_redirect(32'hbfc0_0000);
    endtask

    task automatic test_sequential();
        n_pops = 0;
        repeat (30) bus_cycle(1'b0, '0, 1'b1, 100, 1, 1);
        n_cmp++;
        if (first_hs_addr !== 32'h1fc0_0000 || first_pop_pc !== 32'hbfc0_0000) begin
            n_err++;
            $display("FAIL seq_first: got addr=%h pc=%h, required 1fc00000 bfc00000",
                     first_hs_addr, first_pop_pc);
        end
        n_cmp++;
        if (n_pops < 20) begin
            n_err++;
            $display("FAIL seq_throughput: got %0d pops, required >= 20", n_pops);
        end
    endtask

    task automatic test_stall();
        bus_cycle(1'b1, 32'h8000_2000, 1'b0, 100, 1, 1);
        n_hs = 0; n_pops = 0;
        repeat (20) bus_cycle(1'b0, '0, 1'b0, 100, 1, 1);
        n_cmp++;
        if (n_hs != DEPTH || last_req !== 1'b0 || pend.size() != 0) begin
            n_err++;
            $display("FAIL stall_fill: got hs=%0d req=%b pending=%0d, required %0d 0 0",
                     n_hs, last_req, pend.size(), DEPTH);
        end
        repeat (15) bus_cycle(1'b0, '0, 1'b1, 100, 1, 1);
        n_cmp++;
        if (first_pop_pc !== 32'h8000_2000 || n_pops < DEPTH) begin
            n_err++;
            $display("FAIL stall_drain: got first pc=%h pops=%0d, required 80002000 >= %0d",
                     first_pop_pc, n_pops, DEPTH);
        end
    endtask

    task automatic test_redirect();
        bus_cycle(1'b1, 32'h8000_0400, 1'b1, 100, 4, 4);
        for (int i = 0; i < 10 && pend.size() < 2; i++) bus_cycle(1'b0, '0, 1'b1, 100, 4, 4);
        n_cmp++;
        if (pend.size() != 2) begin
            n_err++;
            $display("FAIL redir_setup: got %0d outstanding, required 2", pend.size());
        end
        bus_cycle(1'b1, 32'h8000_1000, 1'b1, 100, 1, 1);
        n_pops = 0;
        repeat (20) bus_cycle(1'b0, '0, 1'b1, 100, 1, 1);
        n_cmp++;
        if (first_pop_pc !== 32'h8000_1000 || first_hs_addr !== 32'h0000_1000 || n_pops < 5) begin
            n_err++;
            $display("FAIL redir_target: got pc=%h addr=%h pops=%0d, required 80001000 00001000 >=5",
                     first_pop_pc, first_hs_addr, n_pops);
        end
    endtask

    task automatic test_misaligned();
        bus_cycle(1'b1, 32'h8000_0002, 1'b1, 100, 1, 1);
        n_hs = 0; n_pops = 0;
        repeat (15) bus_cycle(1'b0, '0, 1'b1, 100, 1, 1);
        n_cmp++;
        if (n_hs != 0 || n_pops != 1 || first_pop_pc !== 32'h8000_0002) begin
            n_err++;
            $display("FAIL adel: got hs=%0d pops=%0d pc=%h, required 0 1 80000002",
                     n_hs, n_pops, first_pop_pc);
        end
        bus_cycle(1'b1, 32'h8000_0010, 1'b1, 100, 1, 1);
        n_pops = 0;
        repeat (15) bus_cycle(1'b0, '0, 1'b1, 100, 1, 1);
        n_cmp++;
        if (first_pop_pc !== 32'h8000_0010 || n_pops < 5) begin
            n_err++;
            $display("FAIL adel_resume: got pc=%h pops=%0d, required 80000010 >= 5", first_pop_pc, n_pops);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10 && pend.size() < 2; i++) bus_cycle(1'b0, '0, 1'b1, 100, 3, 3);
        bus_cycle(1'b1, 32'h8000_3000, 1'b1, 100, 1, 1);
        bus_cycle(1'b1, 32'h8000_4000, 1'b1, 100, 1, 1);
        n_pops = 0;
        repeat (20) bus_cycle(1'b0, '0, 1'b1, 100, 1, 2);
        n_cmp++;
        if (first_pop_pc !== 32'h8000_4000 || n_pops < 5) begin
            n_err++;
            $display("FAIL b2b_redirect: got pc=%h pops=%0d, required 80004000 >= 5", first_pop_pc, n_pops);
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        bit          r;
        n_pops = 0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(99, 0) < 3);
            case ($urandom_range(3, 0))
                0:       t = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
                1:       t = 32'ha000_0000 | ($urandom & 32'h0000_fffc);
                2:       t = 32'h0040_0000 | ($urandom & 32'h0000_fffc);
                default: t = 32'h8000_0000 | ($urandom & 32'h0000_fff0) | 32'($urandom_range(3, 1));
            endcase
            bus_cycle(r, t, ($urandom_range(99, 0) < 70), 60, 1, 6);
        end
        n_cmp++;
        if (n_pops < 50) begin
            n_err++;
            $display("FAIL random_progress: got %0d pops, required >= 50", n_pops);
        end
    endtask

    task automatic test_async_reset();
        bus_cycle(1'b1, 32'h8000_5000, 1'b0, 100, 6, 6);
        for (int i = 0; i < 10 && pend.size() < 2; i++) bus_cycle(1'b0, '0, 1'b0, 100, 6, 6);
        repeat (3) bus_cycle(1'b0, '0, 1'b0, 0, 6, 6);
        @(negedge clk);
        inst_data_ok = 1'b0; inst_addr_ok = 1'b0; redirect_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (if_valid_out !== 1'b0 || inst_req !== 1'b0 || if_PC_out !== '0 || if_NPC_out !== '0
            || if_NNPC_out !== '0 || if_Instruct_out !== '0 || if_exc_out !== 1'b0
            || if_ExcCode_out !== '0) begin
            n_err++;
            $display("FAIL async_reset: got valid=%b req=%b pc=%h inst=%h exc=%b, required all 0",
                     if_valid_out, inst_req, if_PC_out, if_Instruct_out, if_exc_out);
        end
        pend.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_redirect(32'hbfc0_0000);
        n_pops = 0;
        repeat (20) bus_cycle(1'b0, '0, 1'b1, 100, 1, 1);
        n_cmp++;
        if (first_pop_pc !== 32'hbfc0_0000 || n_pops < 5) begin
            n_err++;
            $display("FAIL reset_restart: got pc=%h pops=%0d, required bfc00000 >= 5", first_pop_pc, n_pops);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_hs = 0; n_pops = 0; cyc = 0;
        first_hs_addr = '0; first_pop_pc = '0; last_req = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
